// File: rtl/guess_pkg.sv
// guess_pkg: shared state encoding, widths and digit-entry helper for the guess game
package guess_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ENTRY = 3'd2,
        S_CHECK = 3'd3,
        S_SHOW  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [3:0] CHEAT_DEFAULT = 4'hF;
    localparam int         TRIES_W       = 4;
    localparam int         TMR_W         = 8;

    function automatic logic [3:0] pick_digit(input logic [3:0] sw, input logic [3:0] secret,
                                              input logic [3:0] cheat);
        return (sw == cheat) ? secret : sw;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter stepped by tick; done while the count sits at zero
module tick_timer
    import guess_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] val,
    input  logic             tick,
    output logic             done
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= val;
        else if (tick && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer - secret latch, digit entry, compare handshake, tries and timeouts
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int         MAX_TRIES     = 8,
    parameter int         TIMEOUT_TICKS = 20,
    parameter int         SHOW_TICKS    = 4,
    parameter int         UNIQUE_DIGITS = 1,
    parameter logic [3:0] CHEAT_CODE    = CHEAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_p,
    input  logic               ge_p,
    input  logic               shi_p,
    input  logic               confirm_p,
    input  logic [3:0]         sw,
    input  logic [7:0]         rand_num,
    input  logic               cmp_valid,
    input  logic [1:0]         cmp_a,
    input  logic [1:0]         cmp_b,
    output logic [3:0]         secret_gw,
    output logic [3:0]         secret_sw,
    output logic [3:0]         code_gw,
    output logic [3:0]         code_sw,
    output logic               cmp_req,
    output logic [1:0]         res_a,
    output logic [1:0]         res_b,
    output logic [TRIES_W-1:0] tries_left,
    output logic [2:0]         state_o,
    output logic               win,
    output logic               lose
);

    localparam logic [TRIES_W-1:0] TRIES_V = TRIES_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]   TO_V    = TMR_W'(TIMEOUT_TICKS);
    localparam logic [TMR_W-1:0]   SH_V    = TMR_W'(SHOW_TICKS);

    state_t             r_state;
    logic               w_dup, w_arm_ok, w_key, w_tout, w_show_end;
    logic               w_ent_load, w_show_load, w_ent_done, w_show_done;
    logic [TRIES_W-1:0] w_tries_dec;

    always_comb begin
        w_dup       = (UNIQUE_DIGITS != 0) && (rand_num[7:4] == rand_num[3:0]);
        w_arm_ok    = (r_state == S_ARM) && !w_dup;
        w_key       = ge_p | shi_p | confirm_p;
        w_tout      = (r_state == S_ENTRY) && !start_p && !w_key && (TIMEOUT_TICKS != 0) && w_ent_done;
        w_show_end  = (r_state == S_SHOW) && !start_p && w_show_done;
        w_ent_load  = w_arm_ok || (w_show_end && tries_left != '0) || ((r_state == S_ENTRY) && w_key);
        w_show_load = w_tout || ((r_state == S_CHECK) && !start_p && cmp_valid && cmp_a != 2'd2);
        w_tries_dec = (tries_left == '0) ? '0 : tries_left - 1'b1;
    end

    tick_timer u_entry_tmr (
        .clk  (clk),
        .rst  (rst),
        .load (w_ent_load),
        .val  (TO_V),
        .tick (tick),
        .done (w_ent_done)
    );

    tick_timer u_show_tmr (
        .clk  (clk),
        .rst  (rst),
        .load (w_show_load),
        .val  (SH_V),
        .tick (tick),
        .done (w_show_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            secret_gw  <= '0;
            secret_sw  <= '0;
            code_gw    <= '0;
            code_sw    <= '0;
            cmp_req    <= 1'b0;
            res_a      <= '0;
            res_b      <= '0;
            tries_left <= TRIES_V;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start_p) r_state <= S_ARM;
                S_ARM: if (w_arm_ok) begin
                    secret_sw  <= rand_num[7:4];
                    secret_gw  <= rand_num[3:0];
                    code_gw    <= '0;
                    code_sw    <= '0;
                    res_a      <= '0;
                    res_b      <= '0;
                    win        <= 1'b0;
                    lose       <= 1'b0;
                    tries_left <= TRIES_V;
                    r_state    <= S_ENTRY;
                end
                S_ENTRY: begin
                    if (start_p)
                        r_state <= S_ARM;
                    else if (ge_p)
                        code_gw <= pick_digit(sw, secret_gw, CHEAT_CODE);
                    else if (shi_p)
                        code_sw <= pick_digit(sw, secret_sw, CHEAT_CODE);
                    else if (confirm_p) begin
                        cmp_req <= 1'b1;
                        r_state <= S_CHECK;
                    end else if (w_tout) begin
                        res_a      <= '0;
                        res_b      <= '0;
                        tries_left <= w_tries_dec;
                        r_state    <= S_SHOW;
                    end
                end
                S_CHECK: begin
                    if (start_p) begin
                        cmp_req <= 1'b0;
                        r_state <= S_ARM;
                    end else if (cmp_valid) begin
                        cmp_req    <= 1'b0;
                        res_a      <= cmp_a;
                        res_b      <= cmp_b;
                        tries_left <= w_tries_dec;
                        win        <= (cmp_a == 2'd2);
                        r_state    <= (cmp_a == 2'd2) ? S_WIN : S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (start_p)
                        r_state <= S_ARM;
                    else if (w_show_end) begin
                        lose    <= (tries_left == '0);
                        r_state <= (tries_left == '0) ? S_LOSE : S_ENTRY;
                    end
                end
                S_WIN, S_LOSE: if (start_p) begin
                    win     <= 1'b0;
                    lose    <= 1'b0;
                    r_state <= S_ARM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state_o = r_state;

endmodule
